// File: rtl/vc_fifo_pkg.sv
// rtl/vc_fifo_pkg.sv - shared widths and count type for the virtual-channel FIFO
package vc_fifo_pkg;

    // Counts are held in a fixed wide type and sliced to CW bits at the ports.
    localparam int MAX_CNT_W = 16;

    typedef logic [MAX_CNT_W-1:0] vc_count_t;

    function automatic int vcw(input int num_vc);
        return (num_vc > 1) ? $clog2(num_vc) : 1;
    endfunction

    function automatic int cw(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/vc_fifo_if.sv
// rtl/vc_fifo_if.sv - write/read handshake and status bundle for vc_fifo (almost_full with VC_FIFO_AFULL_EN)
interface vc_fifo_if
    import vc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int NUM_VC     = 2
) ();

    localparam int VCW = vcw(NUM_VC);
    localparam int CW  = cw(DEPTH);

    logic                   in_valid;
    logic [VCW-1:0]         in_vc;
    logic [DATA_WIDTH-1:0]  in_data;
    logic [NUM_VC-1:0]      in_ready;
    logic [VCW-1:0]         out_vc_sel;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH-1:0]  out_data;
    logic [NUM_VC-1:0]      empty;
    logic [NUM_VC*CW-1:0]   occupancy;
`ifdef VC_FIFO_AFULL_EN
    logic [NUM_VC-1:0]      almost_full;
`endif

    modport master (
        output in_valid, in_vc, in_data, out_vc_sel, out_ready,
`ifdef VC_FIFO_AFULL_EN
        input  almost_full,
`endif
        input  in_ready, out_valid, out_data, empty, occupancy
    );

    modport slave (
        input  in_valid, in_vc, in_data, out_vc_sel, out_ready,
`ifdef VC_FIFO_AFULL_EN
        output almost_full,
`endif
        output in_ready, out_valid, out_data, empty, occupancy
    );

endinterface

// File: rtl/vc_fifo_bank.sv
// rtl/vc_fifo_bank.sv - single-VC storage, pointers and count (afull_o with VC_FIFO_AFULL_EN)
module vc_fifo_bank
    import vc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
`ifdef VC_FIFO_AFULL_EN
    parameter int AFULL_THRESH = 7,
`endif
    parameter int DEPTH        = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic                    rd_en_i,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    output logic [cw(DEPTH)-1:0]    count_o,
`ifdef VC_FIFO_AFULL_EN
    output logic                    afull_o,
`endif
    output logic                    full_o,
    output logic                    empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cw(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    vc_count_t             count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_en_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_en_i ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({wr_en_i, rd_en_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q[CW-1:0];
    assign full_o    = (count_q == vc_count_t'(DEPTH));
    assign empty_o   = (count_q == '0);
`ifdef VC_FIFO_AFULL_EN
    assign afull_o   = (count_q >= vc_count_t'(AFULL_THRESH));
`endif

endmodule

// File: rtl/vc_fifo.sv
// rtl/vc_fifo.sv - multi-VC FWFT FIFO top: VC decode and read mux (almost_full with VC_FIFO_AFULL_EN)
module vc_fifo
    import vc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 8,
    parameter int NUM_VC       = 2,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic      clk,
    input  logic      rst,
    vc_fifo_if.slave  bus
);

    localparam int VCW = vcw(NUM_VC);
    localparam int CW  = cw(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CW > MAX_CNT_W) begin : g_bad_depth
        $error("vc_fifo: DEPTH must be a power of two >= 2");
    end
    if (NUM_VC < 1) begin : g_bad_num_vc
        $error("vc_fifo: NUM_VC must be >= 1");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
        $error("vc_fifo: AFULL_THRESH must be in 1..DEPTH");
    end

    logic [NUM_VC-1:0]     wr_en;
    logic [NUM_VC-1:0]     rd_en;
    logic [NUM_VC-1:0]     full;
    logic [NUM_VC-1:0]     empty;
    logic [DATA_WIDTH-1:0] rd_data [NUM_VC];
    logic [CW-1:0]         count   [NUM_VC];
    logic [NUM_VC*CW-1:0]  occ_c;
    logic                  out_valid_c;
    logic [DATA_WIDTH-1:0] out_data_c;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        // Full and empty come from registered counts only, so in_ready never sees out_ready.
        assign wr_en[v] = bus.in_valid && (bus.in_vc == VCW'(v)) && !full[v];
        assign rd_en[v] = bus.out_ready && (bus.out_vc_sel == VCW'(v)) && !empty[v];

        vc_fifo_bank #(
            .DATA_WIDTH   (DATA_WIDTH),
`ifdef VC_FIFO_AFULL_EN
            .AFULL_THRESH (AFULL_THRESH),
`endif
            .DEPTH        (DEPTH)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .wr_en_i   (wr_en[v]),
            .wr_data_i (bus.in_data),
            .rd_en_i   (rd_en[v]),
            .rd_data_o (rd_data[v]),
            .count_o   (count[v]),
`ifdef VC_FIFO_AFULL_EN
            .afull_o   (bus.almost_full[v]),
`endif
            .full_o    (full[v]),
            .empty_o   (empty[v])
        );
    end

    // Out-of-range selects match no VC and leave the read side idle.
    always_comb begin
        out_valid_c = 1'b0;
        out_data_c  = '0;
        occ_c       = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            occ_c[v*CW +: CW] = count[v];
            if (bus.out_vc_sel == VCW'(v) && !empty[v]) begin
                out_valid_c = 1'b1;
                out_data_c  = rd_data[v];
            end
        end
    end

    assign bus.in_ready  = ~full;
    assign bus.empty     = empty;
    assign bus.occupancy = occ_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_data_c;

endmodule

// File: tb/tb_vc_fifo.sv
// tb/tb_vc_fifo.sv - directed self-checking bench for vc_fifo (almost_full checks with VC_FIFO_AFULL_EN)
module tb_vc_fifo;

    localparam int DW  = 8;
    localparam int DEP = 4;
    localparam int NVC = 2;
    localparam int CWB = 3;

    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    vc_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEP), .NUM_VC(NVC)) bus ();

    vc_fifo #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEP),
        .NUM_VC       (NVC),
        .AFULL_THRESH (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CWB-1:0] occ(input int v);
        return bus.occupancy[v*CWB +: CWB];
    endfunction

    logic [7:0] fill  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] drain [4] = '{8'h22, 8'h33, 8'h44, 8'h66};

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_vc      = '0;
        bus.in_data    = '0;
        bus.out_vc_sel = '0;
        bus.out_ready  = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        #2;
        check("rst_empty",     32'(bus.empty),     32'h3);
        check("rst_in_ready",  32'(bus.in_ready),  32'h3);
        check("rst_occ",       32'(bus.occupancy), 32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_out_data",  32'(bus.out_data),  32'h0);
`ifdef VC_FIFO_AFULL_EN
        check("rst_afull",     32'(bus.almost_full), 32'h0);
`endif

        // Fill VC0 to DEPTH.
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_vc    = 1'b0;
            bus.in_data  = fill[i];
            step();
            #2;
            check("fill_occ", 32'(occ(0)), 32'(i + 1));
`ifdef VC_FIFO_AFULL_EN
            check("fill_afull", 32'(bus.almost_full[0]), 32'((i + 1) >= 3));
`endif
        end
        bus.in_valid = 1'b0;
        #1;
        check("full_occ",      32'(occ(0)),        32'h4);
        check("full_in_ready", 32'(bus.in_ready),  32'h2);
        check("full_head",     32'(bus.out_data),  32'h11);

        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        step();
        bus.in_valid = 1'b0;
        #2;
        check("drop_occ",  32'(occ(0)),       32'h4);
        check("drop_head", 32'(bus.out_data), 32'h11);

        // Full VC0: simultaneous read and write; write must be rejected.
        bus.out_vc_sel = 1'b0;
        bus.out_ready  = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_data    = 8'h66;
        #2;
        check("sim_head",     32'(bus.out_data),    32'h11);
        check("sim_in_ready", 32'(bus.in_ready[0]), 32'h0);
        step();
        bus.out_ready = 1'b0;
        #2;
        check("sim_occ", 32'(occ(0)), 32'h3);
        step();
        bus.in_valid = 1'b0;
        #2;
        check("retry_occ", 32'(occ(0)), 32'h4);

        for (int i = 0; i < 4; i++) begin
            bus.out_ready = 1'b1;
            #2;
            check("drain_valid", 32'(bus.out_valid), 32'h1);
            check("drain_data",  32'(bus.out_data),  32'(drain[i]));
            step();
        end
        bus.out_ready = 1'b0;
        #2;
        check("drain_empty", 32'(bus.empty),     32'h3);
        check("drain_valid", 32'(bus.out_valid), 32'h0);
        check("drain_zero",  32'(bus.out_data),  32'h0);

        // FWFT on VC1 and select isolation.
        bus.in_valid   = 1'b1;
        bus.in_vc      = 1'b1;
        bus.in_data    = 8'hA0;
        bus.out_vc_sel = 1'b1;
        #2;
        check("a0_pre_valid", 32'(bus.out_valid), 32'h0);
        step();
        bus.in_valid = 1'b0;
        #2;
        check("a0_valid", 32'(bus.out_valid), 32'h1);
        check("a0_data",  32'(bus.out_data),  32'hA0);
        bus.out_vc_sel = 1'b0;
        #2;
        check("other_valid", 32'(bus.out_valid), 32'h0);
        check("other_data",  32'(bus.out_data),  32'h0);
        bus.out_vc_sel = 1'b1;
        bus.out_ready  = 1'b1;
        step();
        bus.out_ready = 1'b0;
        #2;
        check("a0_read_empty", 32'(bus.empty), 32'h3);

        // Write to empty VC1 with out_ready high is a write only, then streaming pairs.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_vc     = 1'b1;
        bus.in_data   = 8'h01;
        #2;
        check("wr_empty_valid", 32'(bus.out_valid), 32'h0);
        step();
        #2;
        check("wr_empty_occ", 32'(occ(1)), 32'h1);
        for (int i = 2; i <= 10; i++) begin
            bus.in_data = 8'(i);
            #1;
            check("pair_valid", 32'(bus.out_valid), 32'h1);
            check("pair_data",  32'(bus.out_data),  32'(i - 1));
            step();
            #2;
            check("pair_occ", 32'(occ(1)), 32'h1);
        end
        bus.in_valid = 1'b0;
        #1;
        check("pair_last", 32'(bus.out_data), 32'h0A);
        step();
        bus.out_ready = 1'b0;
        #2;
        check("pair_empty", 32'(bus.empty), 32'h3);

        // Reset beats a concurrent write.
        bus.in_vc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h31 + i);
            step();
        end
        bus.in_data = 8'h34;
        rst         = 1'b1;
        #2;
        check("pre_rst_occ", 32'(occ(0)), 32'h3);
        step();
        rst            = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_vc_sel = 1'b0;
        #2;
        check("post_rst_occ",      32'(bus.occupancy), 32'h0);
        check("post_rst_empty",    32'(bus.empty),     32'h3);
        check("post_rst_data",     32'(bus.out_data),  32'h0);
        check("post_rst_valid",    32'(bus.out_valid), 32'h0);
        check("post_rst_in_ready", 32'(bus.in_ready),  32'h3);
`ifdef VC_FIFO_AFULL_EN
        check("post_rst_afull",    32'(bus.almost_full), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
